// File: rtl/pwrseq_pkg.sv
// pwrseq_pkg: shared types and helpers for the power sequencer.
//   pwrState_t     - sequencer state encoding
//   FAULT_*        - o_faultCode values
//   lowestSet()    - index of the lowest set bit, used to pick the faulting rail
package pwrseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POWER_UP,
    ST_SETTLE,
    ST_RUNNING,
    ST_SHUTDOWN,
    ST_FAULT
  } pwrState_t;

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT   = 2'b01;
  localparam logic [1:0] FAULT_RAIL      = 2'b10;
  localparam logic [1:0] FAULT_GOOD_LOST = 2'b11;

  // Lowest-index rail wins when several report at once.
  function automatic logic [2:0] lowestSet(input logic [7:0] vec);
    logic [2:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (vec[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pwrseq_timer.sv
// pwrseq_timer: loadable saturating up/down counter shared by the timeout,
// settle and power-off delays.
//   i_clk, i_nReset  clock, async active-low reset (count -> 0)
//   i_clear          synchronous clear to 0 (highest priority)
//   i_load           load i_loadValue
//   i_down           count down (saturate at 0) instead of up (saturate at all-ones)
//   i_term           terminal value to compare against
//   o_terminal       count equals i_term
module pwrseq_timer #(
  parameter int unsigned WIDTH = 23
) (
  input  logic             i_clk,
  input  logic             i_nReset,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_down,
  input  logic [WIDTH-1:0] i_term,
  output logic             o_terminal
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_loadValue;
    end else if (i_down) begin
      if (count != '0) count <= count - 1'b1;
    end else begin
      if (count != '1) count <= count + 1'b1;
    end
  end

  assign o_terminal = (count == i_term);

endmodule

// File: rtl/power_sequencer.sv
// power_sequencer: ordered power-up / power-down of NUM_RAILS supply rails.
//   i_clk, i_nReset   clock, async active-low reset
//   i_start           level: high = rails on, low = rails off
//   i_clearFault      pulse: clears a latched fault (only with i_start low)
//   i_railGood        per-rail good from the rail monitors
//   i_railFault       per-rail latched fault from the rail monitors
//   o_railEnable      regulator enables
//   o_allGood         high in RUNNING
//   o_fault           latched fault indicator
//   o_faultCode       00 none, 01 timeout, 10 rail fault, 11 good lost
//   o_faultRail       index of the faulting rail
//   o_busy            high in POWER_UP, SETTLE, SHUTDOWN
// Optional macro PWRSEQ_AUTO_RETRY_EN: automatic restart after timeout or
// good-lost faults, up to MAX_RETRIES attempts.
module power_sequencer
  import pwrseq_pkg::*;
#(
  parameter int unsigned NUM_RAILS      = 4,
  parameter int unsigned CNT_WIDTH      = 23,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned SETTLE_CYCLES  = 1000000,
  parameter int unsigned OFF_CYCLES     = 500000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                 i_clk,
  input  logic                 i_nReset,
  input  logic                 i_start,
  input  logic                 i_clearFault,
  input  logic [NUM_RAILS-1:0] i_railGood,
  input  logic [NUM_RAILS-1:0] i_railFault,
  output logic [NUM_RAILS-1:0] o_railEnable,
  output logic                 o_allGood,
  output logic                 o_fault,
  output logic [1:0]           o_faultCode,
  output logic [2:0]           o_faultRail,
  output logic                 o_busy
);

  if (NUM_RAILS < 2 || NUM_RAILS > 8 || MAX_RETRIES > 255 ||
      TIMEOUT_CYCLES < 1 || SETTLE_CYCLES < 1 || OFF_CYCLES < 1 ||
      64'(TIMEOUT_CYCLES) > (64'd1 << CNT_WIDTH) ||
      64'(SETTLE_CYCLES)  > (64'd1 << CNT_WIDTH) ||
      64'(OFF_CYCLES)     > (64'd1 << CNT_WIDTH)) begin : gBadParams
    $error("power_sequencer: parameter out of range");
  end

  localparam logic [2:0]           LAST_RAIL    = 3'(NUM_RAILS - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_TERM = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_TERM  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] OFF_TERM     = CNT_WIDTH'(OFF_CYCLES - 1);

  function automatic logic [NUM_RAILS-1:0] belowMask(input logic [2:0] n);
    logic [NUM_RAILS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_RAILS; i++) m[i] = (i < 32'(n));
    return m;
  endfunction

  function automatic logic [NUM_RAILS-1:0] upToMask(input logic [2:0] n);
    logic [NUM_RAILS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_RAILS; i++) m[i] = (i <= 32'(n));
    return m;
  endfunction

  pwrState_t            state, stateNext;
  logic [2:0]           idx, idxNext;
  logic                 faultNext;
  logic [1:0]           codeNext;
  logic [2:0]           railNext;
  logic [NUM_RAILS-1:0] upTo, below, curBit, faultSet, lostSet, enNext;
  logic [CNT_WIDTH-1:0] term;
  logic                 tc, timerClear;

`ifdef PWRSEQ_AUTO_RETRY_EN
  logic [7:0] retryCnt, retryCntNext;
`endif

  pwrseq_timer #(.WIDTH(CNT_WIDTH)) uTimer (
    .i_clk       (i_clk),
    .i_nReset    (i_nReset),
    .i_clear     (timerClear),
    .i_load      (1'b0),
    .i_loadValue ('0),
    .i_down      (1'b0),
    .i_term      (term),
    .o_terminal  (tc)
  );

  always_comb begin
    unique case (state)
      ST_POWER_UP:          term = TIMEOUT_TERM;
      ST_SETTLE:            term = SETTLE_TERM;
      ST_SHUTDOWN, ST_FAULT: term = OFF_TERM;
      default:              term = '1;
    endcase
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    faultNext = o_fault;
    codeNext  = o_faultCode;
    railNext  = o_faultRail;
`ifdef PWRSEQ_AUTO_RETRY_EN
    retryCntNext = retryCnt;
`endif
    upTo   = upToMask(idx);
    below  = belowMask(idx);
    curBit = upTo & ~below;
    // Rail k is still coming up in POWER_UP, so only rails below it can lose good.
    if (state == ST_RUNNING) begin
      faultSet = i_railFault;
      lostSet  = ~i_railGood;
    end else begin
      faultSet = i_railFault & upTo;
      lostSet  = ~i_railGood & ((state == ST_SETTLE) ? upTo : below);
    end

    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          stateNext = ST_POWER_UP;
          idxNext   = '0;
        end
      end

      ST_POWER_UP, ST_SETTLE, ST_RUNNING: begin
        if (|faultSet) begin
          faultNext = 1'b1;
          codeNext  = FAULT_RAIL;
          railNext  = lowestSet(8'(faultSet));
          stateNext = ST_SHUTDOWN;
        end else if (|lostSet) begin
          faultNext = 1'b1;
          codeNext  = FAULT_GOOD_LOST;
          railNext  = lowestSet(8'(lostSet));
          stateNext = ST_SHUTDOWN;
        end else if (!i_start) begin
          stateNext = ST_SHUTDOWN;
        end else if (state == ST_POWER_UP) begin
          if (|(i_railGood & curBit)) begin
            stateNext = ST_SETTLE;
          end else if (tc) begin
            faultNext = 1'b1;
            codeNext  = FAULT_TIMEOUT;
            railNext  = idx;
            stateNext = ST_SHUTDOWN;
          end
        end else if (state == ST_SETTLE) begin
          if (tc) begin
            if (idx == LAST_RAIL) begin
              stateNext = ST_RUNNING;
            end else begin
              idxNext   = idx + 3'd1;
              stateNext = ST_POWER_UP;
            end
          end
        end
`ifdef PWRSEQ_AUTO_RETRY_EN
        if (state == ST_RUNNING) retryCntNext = '0;
`endif
      end

      // idx names the rail most recently switched off.
      ST_SHUTDOWN: begin
        if (tc) begin
          if (idx == '0) stateNext = o_fault ? ST_FAULT : ST_IDLE;
          else           idxNext   = idx - 3'd1;
        end
      end

      ST_FAULT: begin
        if (i_clearFault && !i_start) begin
          stateNext = ST_IDLE;
          idxNext   = '0;
          faultNext = 1'b0;
          codeNext  = FAULT_NONE;
          railNext  = '0;
`ifdef PWRSEQ_AUTO_RETRY_EN
          retryCntNext = '0;
`endif
        end
`ifdef PWRSEQ_AUTO_RETRY_EN
        else if (o_faultCode != FAULT_RAIL && 32'(retryCnt) < MAX_RETRIES &&
                 tc && i_start) begin
          stateNext    = ST_POWER_UP;
          idxNext      = '0;
          faultNext    = 1'b0;
          codeNext     = FAULT_NONE;
          railNext     = '0;
          retryCntNext = retryCnt + 8'd1;
        end
`endif
      end

      default: stateNext = ST_IDLE;
    endcase

    unique case (stateNext)
      ST_POWER_UP, ST_SETTLE: enNext = upToMask(idxNext);
      ST_RUNNING:             enNext = '1;
      ST_SHUTDOWN:            enNext = belowMask(idxNext);
      default:                enNext = '0;
    endcase

    timerClear = (stateNext != state) || (idxNext != idx);
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      o_railEnable <= '0;
      o_allGood    <= 1'b0;
      o_busy       <= 1'b0;
      o_fault      <= 1'b0;
      o_faultCode  <= FAULT_NONE;
      o_faultRail  <= '0;
    end else begin
      state        <= stateNext;
      idx          <= idxNext;
      o_railEnable <= enNext;
      o_allGood    <= (stateNext == ST_RUNNING);
      o_busy       <= (stateNext == ST_POWER_UP) || (stateNext == ST_SETTLE) ||
                      (stateNext == ST_SHUTDOWN);
      o_fault      <= faultNext;
      o_faultCode  <= codeNext;
      o_faultRail  <= railNext;
    end
  end

`ifdef PWRSEQ_AUTO_RETRY_EN
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) retryCnt <= '0;
    else           retryCnt <= retryCntNext;
  end
`endif

endmodule

// File: tb/tb_power_sequencer.sv
module tb_power_sequencer;

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] good = '0;
  logic [3:0] flt = '0;
  logic [3:0] en;
  logic       allGood, fault, busy;
  logic [1:0] code;
  logic [2:0] rail;

  always #5 clk = ~clk;

  power_sequencer #(
    .NUM_RAILS      (4),
    .CNT_WIDTH      (8),
    .TIMEOUT_CYCLES (20),
    .SETTLE_CYCLES  (5),
    .OFF_CYCLES     (3),
    .MAX_RETRIES    (3)
  ) dut (
    .i_clk        (clk),
    .i_nReset     (nReset),
    .i_start      (start),
    .i_clearFault (clr),
    .i_railGood   (good),
    .i_railFault  (flt),
    .o_railEnable (en),
    .o_allGood    (allGood),
    .o_fault      (fault),
    .o_faultCode  (code),
    .o_faultRail  (rail),
    .o_busy       (busy)
  );

  typedef struct {
    logic        start;
    logic        clr;
    logic [3:0]  good;
    logic [3:0]  flt;
    int unsigned cycles;
    logic [3:0]  en;
    logic        allGood;
    logic        busy;
    logic        fault;
    logic [1:0]  code;
    logic [2:0]  rail;
  } vec_t;

  typedef struct {
    logic [3:0] en;
    logic       allGood;
    logic       busy;
    logic       fault;
    logic [1:0] code;
    logic [2:0] rail;
  } exp_t;

  vec_t vecs[$];
  exp_t expQ[$];
  int unsigned nVec = 0;
  int unsigned nMis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mkExp(int unsigned e, int unsigned ag, int unsigned b,
                                 int unsigned f, int unsigned c, int unsigned r);
    exp_t x;
    x.en = 4'(e); x.allGood = 1'(ag); x.busy = 1'(b);
    x.fault = 1'(f); x.code = 2'(c); x.rail = 3'(r);
    return x;
  endfunction

  task automatic compare(input string name, input exp_t e);
    nVec++;
    if (en !== e.en || allGood !== e.allGood || busy !== e.busy ||
        fault !== e.fault || code !== e.code || rail !== e.rail) begin
      nMis++;
      $display("FAIL %s: got en=%b allGood=%b busy=%b fault=%b code=%b rail=%0d, want en=%b allGood=%b busy=%b fault=%b code=%b rail=%0d",
               name, en, allGood, busy, fault, code, rail,
               e.en, e.allGood, e.busy, e.fault, e.code, e.rail);
    end
  endtask

  task automatic checkInt(input string name, input int unsigned got, input int unsigned want);
    nVec++;
    if (got != want) begin
      nMis++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic void addV(int unsigned s, int unsigned c, int unsigned g, int unsigned f,
                               int unsigned n, int unsigned e, int unsigned ag, int unsigned b,
                               int unsigned ft, int unsigned cd, int unsigned r);
    vec_t v;
    v.start = 1'(s); v.clr = 1'(c); v.good = 4'(g); v.flt = 4'(f); v.cycles = n;
    v.en = 4'(e); v.allGood = 1'(ag); v.busy = 1'(b);
    v.fault = 1'(ft); v.code = 2'(cd); v.rail = 3'(r);
    vecs.push_back(v);
  endfunction

  // Rail k enabled; one cycle later its good arrives; enable k+1 follows 6 edges on.
  function automatic void addRailUp(int unsigned k);
    int unsigned gBefore, gWith;
    gBefore = (1 << k) - 1;
    gWith   = (1 << (k + 1)) - 1;
    addV(1, 0, gBefore, 0, 1, gWith, 0, 1, 0, 0, 0);
    addV(1, 0, gWith,   0, 5, gWith, 0, 1, 0, 0, 0);
    if (k < 3) addV(1, 0, gWith, 0, 1, (1 << (k + 2)) - 1, 0, 1, 0, 0, 0);
    else       addV(1, 0, 'hF,   0, 1, 'hF,                1, 0, 0, 0, 0);
  endfunction

  function automatic void addPowerUp();
    addV(1, 0, 0, 0, 1, 'b0001, 0, 1, 0, 0, 0);
    for (int unsigned k = 0; k < 4; k++) addRailUp(k);
  endfunction

  // Shutdown from RUNNING: rail 3 off at once, then 2,1,0 every 3 cycles, 3 more to finish.
  function automatic void addDown(int unsigned s, int unsigned g, int unsigned f,
                                  int unsigned ft, int unsigned cd, int unsigned r);
    addV(s, 0, g, f, 1, 'b0111, 0, 1, ft, cd, r);
    addV(s, 0, g, f, 3, 'b0011, 0, 1, ft, cd, r);
    addV(s, 0, g, f, 3, 'b0001, 0, 1, ft, cd, r);
    addV(s, 0, g, f, 3, 'b0000, 0, 1, ft, cd, r);
    addV(s, 0, g, f, 2, 'b0000, 0, 1, ft, cd, r);
    addV(s, 0, g, f, 1, 'b0000, 0, 0, ft, cd, r);
  endfunction

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      exp_t e;
      v = vecs[i];
      start = v.start; clr = v.clr; good = v.good; flt = v.flt;
      e.en = v.en; e.allGood = v.allGood; e.busy = v.busy;
      e.fault = v.fault; e.code = v.code; e.rail = v.rail;
      expQ.push_back(e);
      repeat (v.cycles) tick();
      e = expQ.pop_front();
      compare($sformatf("vec%0d", i), e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal power-up, then orderly power-down.
    addPowerUp();
    addDown(0, 'hF, 0, 0, 0, 0);
    addV(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
`ifndef PWRSEQ_AUTO_RETRY_EN
    // Rail 2 never reports good.
    addV(1, 0, 0, 0, 1, 'b0001, 0, 1, 0, 0, 0);
    addRailUp(0);
    addRailUp(1);
    addV(1, 0, 'b0011, 0, 19, 'b0111, 0, 1, 0, 0, 0);
    addV(1, 0, 'b0011, 0, 1,  'b0011, 0, 1, 1, 1, 2);
    addV(1, 0, 'b0011, 0, 3,  'b0001, 0, 1, 1, 1, 2);
    addV(1, 0, 'b0011, 0, 3,  'b0000, 0, 1, 1, 1, 2);
    addV(1, 0, 'b0011, 0, 3,  'b0000, 0, 0, 1, 1, 2);
    addV(1, 0, 'b0011, 0, 6,  'b0000, 0, 0, 1, 1, 2);
    addV(1, 1, 'b0011, 0, 1,  'b0000, 0, 0, 1, 1, 2);
    addV(0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 2);
    addV(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    addV(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Rails 1 and 3 fault together while running.
    addPowerUp();
    addDown(1, 'hF, 'b1010, 1, 2, 1);
    addV(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    addV(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Rail 0 loses good while running; clear with start high is ignored.
    addPowerUp();
    addDown(1, 'b1110, 0, 1, 3, 0);
    addV(1, 1, 'b1110, 0, 1, 0, 0, 0, 1, 3, 0);
    addV(0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 0);
    addV(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    addV(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
`endif

    #3;
    compare("reset", mkExp(0, 0, 0, 0, 0, 0));
    #9 nReset = 1'b1;

    runTable();

`ifdef PWRSEQ_AUTO_RETRY_EN
    begin
      int unsigned rises;
      logic prev;
      rises = 0;
      start = 1'b1; good = '0; flt = '0;
      prev = en[0];
      for (int c = 0; c < 200; c++) begin
        tick();
        if (en[0] && !prev) rises++;
        prev = en[0];
      end
      checkInt("retryAttempts", rises, 4);
      compare("retryLatched", mkExp(0, 0, 0, 1, 1, 0));
      for (int c = 0; c < 60; c++) begin
        tick();
        if (en[0] && !prev) rises++;
        prev = en[0];
      end
      checkInt("retryNoMore", rises, 4);
      start = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      compare("retryCleared", mkExp(0, 0, 0, 0, 0, 0));
    end
`endif

    // Asynchronous reset in the middle of SETTLE(0).
    start = 1'b1; good = '0; flt = '0;
    tick();
    tick();
    good = 4'b0001;
    tick();
    tick();
    tick();
    compare("preReset", mkExp('b0001, 0, 1, 0, 0, 0));
    #2 nReset = 1'b0;
    #1;
    compare("asyncReset", mkExp(0, 0, 0, 0, 0, 0));
    start = 1'b0; good = '0;
    #2 nReset = 1'b1;
    tick();
    compare("afterReset", mkExp(0, 0, 0, 0, 0, 0));
    start = 1'b1;
    tick();
    compare("restartFromIdle", mkExp('b0001, 0, 1, 0, 0, 0));
    start = 1'b0;
    tick();
    compare("abortPowerUp", mkExp(0, 0, 1, 0, 0, 0));
    repeat (3) tick();
    compare("abortDone", mkExp(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
